// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared FSM encoding, idle line level and clog2 helper for the serial frame tx/rx pair
`timescale 1ns/1ps
package serial_frame_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;
  localparam logic SD_IDLE = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer: counts DIV clocks per serial bit; tick marks the last cycle of each bit period
// ports: clk, clr (async active-low), restart (reload to 0), tick
`timescale 1ns/1ps
module bit_timer
  import serial_frame_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic tick
);
  localparam int CW = clog2(DIV) < 1 ? 1 : clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == CW'(DIV - 1);
  assign cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge clr)
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter (start bit, DATA_W bits LSB-first, stop bit, DIV clocks per bit)
// ports: clk, clr (async active-low), load_valid/load_data/load_ready handshake,
//        sd/sd_n serial line and its complement, busy (frame in progress), done (one-cycle completion pulse)
`timescale 1ns/1ps
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              sd,
  output logic              sd_n,
  output logic              busy,
  output logic              done
);
  localparam int IW = clog2(DATA_W + 1);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              done_q, tick, last;
  // the timer reloads on every state change so each state starts a full bit period
  bit_timer #(.DIV(DIV)) u_timer (
    .clk     (clk),
    .clr     (clr),
    .restart (state_d != state_q),
    .tick    (tick)
  );
  assign last = idx_q == IW'(DATA_W - 1);
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE:  if (load_valid) begin
        state_d = S_START;
        sh_d    = load_data;
      end
      S_START: if (tick) state_d = S_DATA;
      S_DATA:  if (tick) begin
        sh_d    = sh_q >> 1;
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? S_STOP : S_DATA;
      end
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      done_q  <= state_q == S_STOP && tick;
    end
  assign sd         = state_q == S_START ? 1'b0 : state_q == S_DATA ? sh_q[0] : SD_IDLE;
  assign sd_n       = ~sd;
  assign busy       = state_q != S_IDLE;
  assign load_ready = state_q == S_IDLE;
  assign done       = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed plus random frames checked against a bit-time model of the serial line
`timescale 1ns/1ps
module tb_serial_frame_tx;
  logic       clk, clr;
  logic       load_valid, load_ready, sd, sd_n, busy, done;
  logic [7:0] load_data;
  logic       lv1, lr1, sd1, sdn1, busy1, done1;
  logic [3:0] ld1;
  int ncmp = 0;
  int nerr = 0;

  serial_frame_tx u0 (
    .clk(clk), .clr(clr), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .sd(sd), .sd_n(sd_n), .busy(busy), .done(done)
  );
  serial_frame_tx #(.DATA_W(4), .DIV(1)) u1 (
    .clk(clk), .clr(clr), .load_valid(lv1), .load_data(ld1),
    .load_ready(lr1), .sd(sd1), .sd_n(sdn1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // line level k cycles after the accept edge: bit number k/dv of start, data LSB-first, stop
  function automatic logic exp_bit(input logic [15:0] d, input int dw, input int dv, input int k);
    int b;
    b = k / dv;
    if (b == 0) return 1'b0;
    if (b <= dw) return d[b-1];
    return 1'b1;
  endfunction

  task automatic start(input logic [7:0] d);
    @(negedge clk);
    chk("ready_before_accept", {15'd0, load_ready}, 16'd1);
    load_valid = 1'b1;
    load_data  = d;
  endtask

  task automatic frame(input logic [7:0] d, input bit inj, input bit chain, input logic [7:0] nd);
    logic e;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        load_valid = inj;
        load_data  = 8'h3C;
      end
      if (k == 2) load_valid = 1'b0;
      e = exp_bit({8'd0, d}, 8, 4, k);
      chk("sd", {15'd0, sd}, {15'd0, e});
      chk("sd_n", {15'd0, sd_n}, {15'd0, !e});
      chk("busy", {15'd0, busy}, 16'd1);
      chk("ready_busy", {15'd0, load_ready}, 16'd0);
      chk("done_mid", {15'd0, done}, 16'd0);
    end
    @(negedge clk);
    chk("done_end", {15'd0, done}, 16'd1);
    chk("busy_end", {15'd0, busy}, 16'd0);
    chk("sd_end", {15'd0, sd}, 16'd1);
    chk("ready_end", {15'd0, load_ready}, 16'd1);
    load_valid = chain;
    load_data  = nd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_sd", {15'd0, sd}, 16'd1);
      chk("idle_busy", {15'd0, busy}, 16'd0);
      chk("idle_done", {15'd0, done}, 16'd0);
    end
  endtask

  task automatic frame1(input logic [3:0] d);
    @(negedge clk);
    chk("r1_ready", {15'd0, lr1}, 16'd1);
    lv1 = 1'b1;
    ld1 = d;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) lv1 = 1'b0;
      chk("r1_sd", {15'd0, sd1}, {15'd0, exp_bit({12'd0, d}, 4, 1, k)});
      chk("r1_busy", {15'd0, busy1}, 16'd1);
      chk("r1_done_mid", {15'd0, done1}, 16'd0);
    end
    @(negedge clk);
    chk("r1_done", {15'd0, done1}, 16'd1);
    chk("r1_sd_end", {15'd0, sd1}, 16'd1);
    @(negedge clk);
    chk("r1_done_clr", {15'd0, done1}, 16'd0);
  endtask

  initial begin
    logic [7:0] d, nd;
    bit c, pc;
    clr = 1'b0; load_valid = 1'b0; load_data = '0; lv1 = 1'b0; ld1 = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      load_valid = !load_valid;
      load_data  = 8'($urandom);
      lv1        = load_valid;
      #1;
      chk("rst_sd", {15'd0, sd}, 16'd1);
      chk("rst_sd_n", {15'd0, sd_n}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_ready", {15'd0, load_ready}, 16'd1);
      chk("rst_sd1", {15'd0, sd1}, 16'd1);
    end
    @(negedge clk);
    load_valid = 1'b0; lv1 = 1'b0;
    clr = 1'b1;
    start(8'hA5);
    frame(8'hA5, 1'b0, 1'b0, 8'h00);
    idle(2);
    start(8'hFF);
    frame(8'hFF, 1'b1, 1'b0, 8'h00);
    idle(8);
    start(8'h01);
    frame(8'h01, 1'b0, 1'b1, 8'h80);
    frame(8'h80, 1'b0, 1'b0, 8'h00);
    idle(2);
    start(8'h00);
    @(negedge clk);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_sd", {15'd0, sd}, 16'd0);
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    #2 clr = 1'b0;
    #1;
    chk("async_sd", {15'd0, sd}, 16'd1);
    chk("async_sd_n", {15'd0, sd_n}, 16'd0);
    chk("async_busy", {15'd0, busy}, 16'd0);
    chk("async_ready", {15'd0, load_ready}, 16'd1);
    #1 clr = 1'b1;
    idle(2);
    start(8'h55);
    frame(8'h55, 1'b0, 1'b0, 8'h00);
    idle(1);
    pc = 1'b0;
    d  = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      nd = 8'($urandom);
      c  = ($urandom_range(0, 1) == 1) && (i < 5);
      if (!pc) start(d);
      frame(d, 1'b0, c, nd);
      if (!c) idle(1);
      pc = c;
      d  = nd;
    end
    frame1(4'b1001);
    for (int i = 0; i < 3; i++) frame1(4'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-to-serial frame transmitter. It produces the single-bit data stream that the lab's D flip-flop and shift-register receivers sample on `clk`. It accepts a parallel word through a valid/ready handshake and emits it as one start bit, the data bits LSB-first, and one stop bit. Each bit is held for a programmable number of clock cycles. It sits between the lab's switch/register front end and any serial capture stage.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- DIV, 4, clock cycles each serial bit is held (>=1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  reset; one clock; asynchronous, active-low (clr=0 resets immediately, independent of clk).
- load_valid  input  1  parallel word offered this cycle.
- load_data  input  DATA_W  word to transmit; sampled only on handshake.
- load_ready  output  1  block can accept a word (high only in IDLE).
- sd  output  1  serial data out; idle level 1.
- sd_n  output  1  always the complement of sd.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, sd=1, sd_n=0, busy=0, done=0, load_ready=1.
  - Shift register and counters are cleared.
  - Applies immediately, including mid-frame; the partial frame is abandoned and not resumed.
  - Releasing clr resumes normal operation from IDLE at the next clk edge.
- All outputs are registered or decoded directly from registered state; there is no combinational path from load_valid to any output.
- Handshake: a word is accepted at a clk edge where load_valid=1 and load_ready=1.
  - load_data is captured into the shift register on that edge.
  - load_valid while busy is ignored; no queuing, no error.
  - load_data need not be held after acceptance.
- FSM states and transitions:
  - IDLE: sd=1. On accept, go to START.
  - START: sd=0 for DIV cycles, then go to DATA.
  - DATA: sd = shift register LSB. Every DIV cycles, shift right by one and increment the bit index. After DATA_W bits, go to STOP.
  - STOP: sd=1 for DIV cycles, then go to IDLE, asserting done for exactly the first IDLE cycle.
- Latency and timing:
  - sd goes low in the cycle immediately after the accept edge.
  - Frame length is exactly (DATA_W+2)*DIV cycles from the first START cycle to the first IDLE cycle.
  - Back-to-back frames: a new word may be accepted in the same cycle done=1. The next START then follows immediately, with no extra idle bit beyond the stop bit.
- Bit-time counter:
  - Counts 0..DIV-1, reloads to 0 on the final count and on every state entry.
  - Width is clog2(DIV), minimum 1.
  - DIV=1 gives one cycle per bit; the counter stays constant and each state advances every cycle.
- Bit index: width clog2(DATA_W+1); wraps to 0 on entry to STOP.
- Output relationships: busy = (state != IDLE); load_ready = (state == IDLE). sd_n = ~sd at all times, including during reset.
- Unused FSM encodings return to IDLE on the next edge with sd=1.

Decomposition:
- Shared package `serial_frame_pkg`:
  - state encoding constants S_IDLE, S_START, S_DATA, S_STOP (2-bit);
  - SD_IDLE=1'b1;
  - a clog2 constant function.
  - The matching receiver reuses this package.
- One sub-module: `bit_timer`. Parameter DIV; inputs clk, clr, restart; output tick, high on the last cycle of each bit period.

Test Plan:
- Reset values: hold clr=0 for 100 ns with load_valid toggling -> sd=1, sd_n=0, busy=0, done=0, load_ready=1 throughout.
- Basic frame (DATA_W=8, DIV=4): accept 8'hA5 -> sd sequence over 4-cycle bits is 0, 1,0,1,0,0,1,0,1, 1. busy is high for 40 cycles, then done=1 for exactly 1 cycle.
- Busy rejection: offer 8'h3C in the cycle after accepting 8'hFF -> load_ready=0, 8'h3C is not sent. After done, the line stays at 1 until load_valid is asserted again.
- Back-to-back: hold load_valid=1 with 8'h01, then 8'h80 presented in the done cycle -> two contiguous 40-cycle frames with no gap: stop bit of frame 1 followed directly by start bit of frame 2.
- Async reset mid-frame: drive clr=0 between clock edges during the 3rd data bit of 8'h00 -> sd=1 and busy=0 before the next rising edge. After release, a fresh frame of 8'h55 is transmitted correctly.
- DIV=1, DATA_W=4: accept 4'b1001 -> sd = 0,1,0,0,1,1 on six consecutive cycles; done on cycle 7.
